// File: rtl/camera_capture.sv
// Pairs camera bytes into RGB565 pixels and writes exactly one frame per shutter press.
// Optional CAPTURE_LINE_CHECK_EN counts captured lines whose pixel count is not H_ACTIVE.
module camera_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fpga_href,
  input  logic              fpga_vsync,
  input  logic [7:0]        fpga_data,
  input  logic              fpga_shutter,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        err_lines
);
  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX     = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [2:0] {IDLE, ARMED, SYNC, CAPTURE, DONE} state_t;

  state_t              state_q, state_d;
  logic                href_q, href_d, href_p_q, href_p_d;
  logic                vsync_q, vsync_d, vsync_p_q, vsync_p_d;
  logic [7:0]          data_q, data_d, hi_q, hi_d;
  logic                sh_meta_q, sh_meta_d, sh_sync_q, sh_sync_d, sh_prev_q, sh_prev_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic                phase_q, phase_d, wr_en_q, wr_en_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                sh_rise, vs_rise, vs_fall, href_fall, pix_fire;

  assign sh_rise   = sh_sync_q & ~sh_prev_q;
  assign vs_rise   = vsync_q & ~vsync_p_q;
  assign vs_fall   = ~vsync_q & vsync_p_q;
  assign href_fall = ~href_q & href_p_q;
  // A vsync rise ends the frame and wins over any byte arriving on the same cycle.
  assign pix_fire  = (state_q == CAPTURE) && !vs_rise && href_q && phase_q;

  always_comb begin
    href_d    = fpga_href;
    href_p_d  = href_q;
    vsync_d   = fpga_vsync;
    vsync_p_d = vsync_q;
    data_d    = fpga_data;
    sh_meta_d = fpga_shutter;
    sh_sync_d = sh_meta_q;
    sh_prev_d = sh_sync_q;
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE:  if (sh_rise) state_d = ARMED;
      ARMED: if (vs_rise) state_d = SYNC;
      SYNC: begin
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        phase_d = 1'b0;
        if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise) begin
          state_d = DONE;
        end else if (href_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_q;
          end else begin
            if (x_q < X_MAX && y_q < Y_MAX) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {hi_q, data_q};
              if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
            end
            if (x_q < X_MAX) x_d = x_q + 1'b1;
          end
        end else if (href_fall) begin
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q < Y_MAX) y_d = y_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      href_q    <= 1'b0;
      href_p_q  <= 1'b0;
      vsync_q   <= 1'b0;
      vsync_p_q <= 1'b0;
      data_q    <= '0;
      hi_q      <= '0;
      sh_meta_q <= 1'b0;
      sh_sync_q <= 1'b0;
      sh_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      href_q    <= href_d;
      href_p_q  <= href_p_d;
      vsync_q   <= vsync_d;
      vsync_p_q <= vsync_p_d;
      data_q    <= data_d;
      hi_q      <= hi_d;
      sh_meta_q <= sh_meta_d;
      sh_sync_q <= sh_sync_d;
      sh_prev_q <= sh_prev_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef CAPTURE_LINE_CHECK_EN
  // px counts completed pixels in the current line, saturating one past H_ACTIVE.
  localparam logic [XW-1:0] PX_SAT = XW'(H_ACTIVE + 1);
  logic [XW-1:0] px_q, px_d;
  logic [7:0]    err_q, err_d;

  always_comb begin
    px_d  = px_q;
    err_d = err_q;
    if (state_q == ARMED && vs_rise) err_d = '0;
    if (state_q == SYNC) px_d = '0;
    if (pix_fire && px_q != PX_SAT) px_d = px_q + 1'b1;
    if (state_q == CAPTURE && !vs_rise && !href_q && href_fall) begin
      px_d = '0;
      if (y_q < Y_MAX && px_q != X_MAX && err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      px_q  <= '0;
      err_q <= '0;
    end else begin
      px_q  <= px_d;
      err_q <= err_d;
    end
  end

  assign err_lines = err_q;
`else
  assign err_lines = 8'd0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q == ARMED) || (state_q == SYNC) || (state_q == CAPTURE);
  assign frame_done = (state_q == DONE);
endmodule

// File: doc/camera_capture.md
Name: camera_capture

Overview:
- Downstream consumer of the camera I/O stage.
- Takes its byte stream (fpga_href, fpga_vsync, fpga_data, fpga_shutter) and pairs bytes into RGB565 pixels.
- On a shutter request, captures exactly one complete frame into a frame-buffer write port.
- Emits write strobes with linear addresses, plus a done pulse when the frame is complete.

Parameters:
- H_ACTIVE, 640: pixels per line stored; extra pixels in a line are dropped.
- V_ACTIVE, 480: lines per frame stored; extra lines are dropped.
- ADDR_W, 19: frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  pixel clock, sourced from fpga_pclk; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- fpga_href  in  1  line-valid from the camera I/O stage.
- fpga_vsync  in  1  frame sync; high pulse between frames.
- fpga_data  in  8  one RGB565 byte per cycle while href=1.
- fpga_shutter  in  1  asynchronous level from the switch; a rising edge requests a capture.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  linear address, y*H_ACTIVE+x.
- wr_data  out  16  RGB565 pixel, {first byte, second byte}.
- busy  out  1  high from the accepted shutter edge until frame_done.
- frame_done  out  1  one-cycle pulse when capture completes.
- err_lines  out  8  short/long line count (see Optional Feature).

Behaviour:
- Reset (reset=0 on a clk edge): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err_lines=0; all counters, the byte phase and the shutter synchroniser cleared.
- Input handling:
  - href, vsync and data are registered once (stage R).
  - shutter passes through a 2-flop synchroniser plus a rising-edge detector.
  - The registered vsync gets its own edge detector.
- State machine:
  - IDLE: a shutter rising edge -> ARMED, busy=1. All other inputs are ignored.
  - ARMED: vsync rising edge -> SYNC. This discards any partial frame in progress.
  - SYNC: vsync falling edge -> CAPTURE; x=0, y=0, addr=0, phase=0.
  - CAPTURE: pixel assembly (below). Next vsync rising edge -> DONE.
  - DONE: frame_done=1 for exactly one cycle, busy=0 -> IDLE.
- Pixel assembly in CAPTURE:
  - While R.href=1, phase toggles every cycle.
  - phase=0: latch the byte as the high byte.
  - phase=1: form the pixel. If x<H_ACTIVE and y<V_ACTIVE, assert wr_en for one cycle with wr_data={hi,lo} and wr_addr=addr, then increment addr. x increments in either case, saturating at H_ACTIVE.
  - Latency: wr_en is asserted 2 clk after the second byte appears on fpga_data.
- Line handling:
  - On an href falling edge: y increments (saturating at V_ACTIVE), x=0, phase=0.
  - An odd byte left at line end is discarded.
  - addr is not re-derived per line: short lines are not padded; addr is simply the count of pixels written.
- Boundaries and simultaneous events:
  - A shutter edge outside IDLE (ARMED/SYNC/CAPTURE/DONE) is ignored, not queued.
  - A vsync rising edge while href=1 in CAPTURE: the frame ends; a pending high byte is discarded.
  - addr never exceeds H_ACTIVE*V_ACTIVE-1.
  - reset=0 mid-capture: wr_en deasserts on that same edge, no frame_done is issued, state -> IDLE.
- wr_en is 0 in every state other than CAPTURE.

Optional Feature:
- Macro: CAPTURE_LINE_CHECK_EN.
- Defined:
  - At each href falling edge in CAPTURE with y<V_ACTIVE, a line whose completed pixel count is not H_ACTIVE increments err_lines (saturating at 255).
  - err_lines clears on entry to SYNC.
  - err_lines holds its value after DONE until the next capture.
- Not defined: err_lines is tied to 0 and the checking logic is absent.

Test Plan (H_ACTIVE=4, V_ACTIVE=3, ADDR_W=4 unless stated):
- Nominal capture: shutter edge, vsync pulse, then 3 lines of 8 bytes 0x00..0x17 -> 12 writes at addr 0..11 with data 0x0001, 0x0203 … 0x1617; frame_done pulses once after the next vsync rise; busy low afterwards.
- Shutter mid-frame: shutter rises while href is active -> no writes until after the next vsync fall; the next full frame is captured from addr 0.
- Long line / extra lines: 5 lines of 10 bytes -> only 12 writes, addr capped at 11, x and y saturate. err_lines=3 with CAPTURE_LINE_CHECK_EN defined, 0 without.
- Odd/short line: line 1 has 7 bytes -> that line makes 3 writes and its last byte is dropped; the next line's first pixel lands at addr 7. err_lines=1 with the macro defined.
- Reset during capture: reset=0 after 5 writes -> wr_en=0 on that edge; busy=0, frame_done never pulses; a new shutter edge later restarts from addr 0.
- Second shutter edge during CAPTURE: no second capture; exactly one frame_done is produced.
